// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array input staging logic.
//   SA_ROW / SA_WIDTH / SA_DEPTH : default array rows, element width, FIFO depth
//   state_t                      : skew FSM state encoding
//   cnt_width()                  : width of a counter covering 0..n-1 (at least 1 bit)
package sa_pkg;

    localparam int SA_ROW   = 9;
    localparam int SA_WIDTH = 9;
    localparam int SA_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port.
//   i_clk, i_rst_n : clock, async active-low reset
//   push, wdata    : write request and data (ignored while full)
//   pop            : read request (ignored while empty); head moves to rdata next cycle
//   rdata          : registered read data, holds between pops
//   empty, full    : occupancy flags, both taken before this cycle's push/pop
module sync_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int DEPTH = SA_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = rdata_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rdata_d  = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/row_skew_fifo_bank.sv
// Input staging for the systolic array: one FIFO per array row, with zero
// padding so that row r lags row 0 by r slots (diagonal wavefront).
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_valid, i_last, i_data : upstream vector stream, row r in i_data[r*WIDTH +: WIDTH]
//   o_ready                 : vector accepted when i_valid & o_ready
//   i_read_enable           : per-row pop request
//   o_fifo_empty            : per-row empty flag
//   o_data                  : per-row registered read data, same packing as i_data
//   o_busy                  : FSM not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first i_valid of a burst (vector not consumed)
// PRE   | inserting leading zeros, row r gets r of them
// DATA  | accepting vectors, every row written in the same cycle
// FLUSH | inserting trailing zeros, row r gets ROW-1-r of them
module row_skew_fifo_bank
    import sa_pkg::*;
#(
    parameter int ROW   = SA_ROW,
    parameter int WIDTH = SA_WIDTH,
    parameter int DEPTH = SA_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_last,
    input  logic [ROW*WIDTH-1:0] i_data,
    output logic                 o_ready,
    input  logic [ROW-1:0]       i_read_enable,
    output logic [ROW-1:0]       o_fifo_empty,
    output logic [ROW*WIDTH-1:0] o_data,
    output logic                 o_busy
);

    localparam int KW = cnt_width(ROW);

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [ROW-1:0]             push, full, empty;
    logic [ROW-1:0][WIDTH-1:0]  wdata, rdata;
    logic                       any_full, k_last, accept;

    // Every phase step and every accept is gated on "no row full" so that
    // all rows advance in lockstep and never drift relative to each other.
    assign any_full = |full;
    assign k_last   = (int'(k_q) == ROW - 2);
    assign accept   = (state_q == DATA) & i_valid & ~any_full;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = (ROW > 1) ? PRE : DATA;
                    k_d     = '0;
                end
            end
            PRE: begin
                if (!any_full) begin
                    if (k_last) begin
                        state_d = DATA;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DATA: begin
                if (accept && i_last) begin
                    state_d = (ROW > 1) ? FLUSH : IDLE;
                    k_d     = '0;
                end
            end
            FLUSH: begin
                if (!any_full) begin
                    if (k_last) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Zero-insert mux: in PRE the deep rows start first, in FLUSH the shallow
    // rows keep going longest, giving r leading and ROW-1-r trailing zeros.
    always_comb begin
        for (int r = 0; r < ROW; r++) begin
            push[r]  = 1'b0;
            wdata[r] = '0;
            case (state_q)
                PRE:     push[r] = ~any_full & (int'(k_q) >= ROW - 1 - r);
                DATA: begin
                    push[r]  = accept;
                    wdata[r] = i_data[r*WIDTH +: WIDTH];
                end
                FLUSH:   push[r] = ~any_full & (int'(k_q) < ROW - 1 - r);
                default: push[r] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row
        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .push    (push[r]),
            .pop     (i_read_enable[r]),
            .wdata   (wdata[r]),
            .rdata   (rdata[r]),
            .empty   (empty[r]),
            .full    (full[r])
        );
    end

    assign o_ready      = (state_q == DATA) & ~any_full;
    assign o_busy       = (state_q != IDLE);
    assign o_fifo_empty = empty;
    assign o_data       = rdata;

endmodule

// File: tb/tb_row_skew_fifo_bank.sv
module tb_row_skew_fifo_bank;

    logic clk;
    logic rst_n;

    // ROW=3, DEPTH=8 instance
    logic        v, l;
    logic [26:0] d;
    logic [2:0]  rd;
    logic        ready, busy;
    logic [2:0]  empty;
    logic [26:0] odata;

    // ROW=1 instance
    logic        v1, l1;
    logic [8:0]  d1;
    logic [0:0]  rd1;
    logic        ready1, busy1;
    logic [0:0]  empty1;
    logic [8:0]  odata1;

    int n_chk;
    int n_fail;

    logic [8:0] got [3][$];

    row_skew_fifo_bank #(.ROW(3), .WIDTH(9), .DEPTH(8)) dut3 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (v),
        .i_last        (l),
        .i_data        (d),
        .o_ready       (ready),
        .i_read_enable (rd),
        .o_fifo_empty  (empty),
        .o_data        (odata),
        .o_busy        (busy)
    );

    row_skew_fifo_bank #(.ROW(1), .WIDTH(9), .DEPTH(4)) dut1 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (v1),
        .i_last        (l1),
        .i_data        (d1),
        .o_ready       (ready1),
        .i_read_enable (rd1),
        .o_fifo_empty  (empty1),
        .o_data        (odata1),
        .o_busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [26:0] d;
        logic [2:0]  rd;
        logic        e_rdy;
        logic        e_busy;
        logic [2:0]  e_empty;
        logic [26:0] e_data;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [26:0] pk(input int a, input int b, input int c);
        return {9'(c), 9'(b), 9'(a)};
    endfunction

    function automatic vec_t mk(input logic vv, input logic ll, input logic [26:0] dd,
                                input logic [2:0] rr, input logic er, input logic eb,
                                input logic [2:0] ee, input logic [26:0] ed);
        vec_t t;
        t.v = vv; t.l = ll; t.d = dd; t.rd = rr;
        t.e_rdy = er; t.e_busy = eb; t.e_empty = ee; t.e_data = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v = 1'b0; l = 1'b0; d = '0; rd = '0;
        v1 = 1'b0; l1 = 1'b0; d1 = '0; rd1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            v = tbl[i].v; l = tbl[i].l; d = tbl[i].d; rd = tbl[i].rd;
            #1;
            chk($sformatf("%s_rdy_%0d", tag, i), 32'(ready), 32'(tbl[i].e_rdy));
            chk($sformatf("%s_busy_%0d", tag, i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("%s_empty_%0d", tag, i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("%s_data_%0d", tag, i), 32'(odata), 32'(tbl[i].e_data));
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    // Advance one cycle, logging the value of every row that was popped.
    task automatic step_rec();
        logic [2:0] pf;
        pf = rd & ~empty;
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            if (pf[r]) got[r].push_back(odata[r*9 +: 9]);
        end
    endtask

    function automatic logic [26:0] vecv(input int j);
        return pk(1 + j, 33 + j, 65 + j);
    endfunction

    initial begin
        int acc;
        int lim;
        n_chk  = 0;
        n_fail = 0;

        // after reset: idle, pop-on-empty ignored; then burst {1,2,3},{4,5,6}; then drain
        tbl[0]  = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b111, pk(0,0,0));
        tbl[1]  = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b111, pk(0,0,0));
        tbl[2]  = mk(1, 0, pk(1,2,3), 3'b000, 0, 0, 3'b111, pk(0,0,0));
        tbl[3]  = mk(1, 0, pk(1,2,3), 3'b000, 0, 1, 3'b111, pk(0,0,0));
        tbl[4]  = mk(1, 0, pk(1,2,3), 3'b000, 0, 1, 3'b011, pk(0,0,0));
        tbl[5]  = mk(1, 0, pk(1,2,3), 3'b000, 1, 1, 3'b001, pk(0,0,0));
        tbl[6]  = mk(1, 1, pk(4,5,6), 3'b000, 1, 1, 3'b000, pk(0,0,0));
        tbl[7]  = mk(0, 0, pk(0,0,0), 3'b000, 0, 1, 3'b000, pk(0,0,0));
        tbl[8]  = mk(0, 0, pk(0,0,0), 3'b000, 0, 1, 3'b000, pk(0,0,0));
        tbl[9]  = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b000, pk(0,0,0));
        tbl[10] = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b000, pk(1,0,0));
        tbl[11] = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b000, pk(4,2,0));
        tbl[12] = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b000, pk(0,5,3));
        tbl[13] = mk(0, 0, pk(0,0,0), 3'b000, 0, 0, 3'b111, pk(0,0,6));
        tbl[14] = mk(0, 0, pk(0,0,0), 3'b111, 0, 0, 3'b111, pk(0,0,6));
        tbl[15] = mk(0, 0, pk(0,0,0), 3'b000, 0, 0, 3'b111, pk(0,0,6));

        do_reset();
        run_table("burst");

        // ROW=1: single vector 7 with last
        do_reset();
        v1 = 1'b1; l1 = 1'b1; d1 = 9'd7;
        #1;
        chk("r1_idle_rdy", 32'(ready1), 32'd0);
        chk("r1_idle_busy", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        chk("r1_data_rdy", 32'(ready1), 32'd1);
        chk("r1_data_busy", 32'(busy1), 32'd1);
        chk("r1_data_empty", 32'(empty1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0; l1 = 1'b0;
        #1;
        chk("r1_back_idle", 32'(busy1), 32'd0);
        chk("r1_not_empty", 32'(empty1), 32'd0);
        rd1 = 1'b1;
        @(posedge clk); #1;
        rd1 = 1'b0;
        #1;
        chk("r1_pop_data", 32'(odata1), 32'd7);
        chk("r1_one_entry", 32'(empty1), 32'd1);

        // fill until full, backpressure, then flush with stall and drain
        do_reset();
        acc = 0;
        v = 1'b1; d = vecv(0);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) acc++;
            else if (acc > 0) break;
            step_rec();
            d = vecv(acc);
        end
        chk("accepts_before_full", 32'(acc), 32'd6);
        chk("full_empty_flags", 32'(empty), 32'd0);
        step_rec();
        #1;
        chk("rdy_hold_full", 32'(ready), 32'd0);
        rd = 3'b111;
        #1;
        chk("rdy_full_during_pop", 32'(ready), 32'd0);
        step_rec();
        rd = 3'b000;
        #1;
        chk("rdy_back_after_pop", 32'(ready), 32'd1);
        step_rec();
        d = vecv(7);
        #1;
        chk("rdy_refull", 32'(ready), 32'd0);
        rd = 3'b111;
        #1;
        step_rec();
        rd = 3'b000; l = 1'b1;
        #1;
        chk("rdy_for_last", 32'(ready), 32'd1);
        step_rec();
        v = 1'b0; l = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_no_rdy", 32'(ready), 32'd0);
        step_rec();
        #1;
        chk("flush_stalled", 32'(busy), 32'd1);
        rd = 3'b111;
        lim = 0;
        while (lim < 60 && (busy || empty != 3'b111)) begin
            step_rec();
            lim++;
        end
        rd = 3'b000;
        #1;
        chk("drain_done_idle", 32'(busy), 32'd0);
        chk("drain_done_empty", 32'(empty), 32'd7);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("row%0d_len", r), 32'(got[r].size()), 32'd10);
            for (int j = 0; j < 10 && j < got[r].size(); j++) begin
                int e;
                e = (j < r) ? 0 : (j < r + 8) ? (r * 32 + (j - r) + 1) : 0;
                chk($sformatf("row%0d_entry%0d", r, j), 32'(got[r][j]), 32'(e));
            end
        end

        // reset asserted mid-PRE (k=1), then the burst pattern again
        do_reset();
        v = 1'b1; d = pk(1,2,3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_k1_busy", 32'(busy), 32'd1);
        chk("pre_k1_empty", 32'(empty), 32'd3);
        #2 rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd7);
        chk("rst_data", 32'(odata), 32'd0);
        chk("rst_rdy", 32'(ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_table("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/row_skew_fifo_bank.md
# row_skew_fifo_bank

Input staging stage of the systolic array, directly upstream of the row read controller. Accepts bursts of row vectors on a valid/ready stream and splits each vector into one FIFO per array row. It pads the rows with zeros so that row r is delayed by r slots, producing the diagonal wavefront the array needs. It exposes per-row `empty` flags, `read_enable` inputs and registered data outputs; the row read controller drains it.

## Interface
- `ROW`, 9, number of array rows / FIFOs.
- `WIDTH`, 9, bits per element.
- `DEPTH`, 16, entries per FIFO; power of two, ≥ 4.
- `i_clk` input 1: rising-edge clock; the only clock.
- `i_rst_n` input 1: reset, asynchronous assert, active-low.
- `i_valid` input 1: upstream vector valid.
- `i_last` input 1: qualifies the final vector of a burst; sampled with `i_valid`.
- `i_data` input ROW*WIDTH: vector; row r in bits [r*WIDTH +: WIDTH].
- `o_ready` output 1: vector accepted when `i_valid & o_ready`.
- `i_read_enable` input ROW: per-row pop request.
- `o_fifo_empty` output ROW: per-row empty flag.
- `o_data` output ROW*WIDTH: per-row registered read data, same packing as `i_data`.
- `o_busy` output 1: state ≠ IDLE.

## Operation
- FSM states:
  - IDLE → PRE on the first `i_valid` (that vector is not consumed in IDLE).
  - PRE → DATA after ROW-1 advancing cycles.
  - DATA → FLUSH when a vector is accepted with `i_last=1`.
  - FLUSH → IDLE after ROW-1 advancing cycles.
  - For ROW=1: IDLE→DATA directly; FLUSH is skipped (DATA→IDLE on last).
- Phase counter k, 0..ROW-2, width $clog2(ROW) (min 1). It advances only when no FIFO is full.
- PRE, cycle k: row r writes 0 iff k ≥ ROW-1-r. Row r receives exactly r leading zeros.
- DATA: `o_ready = ~|full`. An accepted vector writes every row in the same cycle.
- FLUSH, cycle k: row r writes 0 iff k < ROW-1-r. Row r receives ROW-1-r trailing zeros.
- Every row therefore receives N+ROW-1 entries per burst of N vectors.
- `o_ready` is 0 in IDLE, PRE and FLUSH.
- Any write to a full FIFO is forbidden. The FSM stalls on any full FIFO, so the rows never drift.
- Pop: `i_read_enable[r] & ~empty[r]` pops the head into `o_data[r]`. Read while empty is ignored and `o_data[r]` holds.
- Same-cycle push and pop on one row are both allowed. Full is evaluated before the pop, so a full FIFO still refuses the push that cycle.
- Occupancy counter per FIFO: $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - FSM = IDLE, k = 0, all pointers and counts = 0.
  - `o_fifo_empty` = all ones, `o_data` = 0, `o_ready` = 0, `o_busy` = 0.
- Reset asserted mid-burst discards all contents immediately (asynchronous). No partial flush.
- Write-to-read: an entry written in cycle t clears `empty` at t+1 and may be popped at t+1.
- Read latency: `o_data[r]` updates one cycle after the accepted pop and then holds.
- Burst latency with no stalls: first real vector is accepted ROW cycles after `i_valid` rises in IDLE (1 IDLE cycle + ROW-1 PRE cycles).
- FSM is back in IDLE ROW-1 cycles after the last vector.
- A new `i_valid` seen in FLUSH waits (no `o_ready`) until IDLE.

## Structure
- Shared package `sa_pkg`:
  - `ROW` and `WIDTH` defaults.
  - FSM state enum {IDLE, PRE, DATA, FLUSH}.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports push, pop, wdata, rdata, empty, full), instantiated ROW times via generate.
- The top level holds the FSM, phase counter and zero-insert muxing.

## Test plan
- ROW=3, DEPTH=8; burst of 2 vectors {r0,r1,r2} = {1,2,3}, {4,5,6} with `i_last` on the second; no reads → rows hold:
  - row0: 1,4,0,0
  - row1: 0,2,5,0
  - row2: 0,0,3,6
- Same burst, then pop each row 4 times, one pop per cycle → `o_data` sequence per row matches the above, each value appearing one cycle after its pop. `empty` rises after the 4th pop.
- Fill with no reads until a FIFO is full → `o_ready` drops the cycle any FIFO shows full. No FIFO count ever exceeds 8. Pop 1 entry from all rows → `o_ready` returns next cycle.
- Pop on an empty row, `i_read_enable=3'b111` after reset → empties stay 1 and `o_data` stays 0.
- Assert `i_rst_n=0` during PRE with k=1 → `o_busy=0`, all empty=1 immediately. After release, a new burst produces the exact pattern of scenario 1.
- ROW=1, single vector 7 with `i_last` → FIFO holds exactly one entry, 7. FSM returns to IDLE the next cycle.
